// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the HD44780 character writer and
// the keypad decode stage that feeds it.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] HOME     = 8'h02;
  localparam logic [7:0] LINE0    = 8'h80;
  localparam logic [7:0] LINE1    = 8'hC0;

  localparam logic [7:0] ASCII_BLANK = 8'h20;
  localparam logic [7:0] ASCII_0 = 8'h30, ASCII_1 = 8'h31, ASCII_2 = 8'h32, ASCII_3 = 8'h33;
  localparam logic [7:0] ASCII_4 = 8'h34, ASCII_5 = 8'h35, ASCII_6 = 8'h36, ASCII_7 = 8'h37;
  localparam logic [7:0] ASCII_8 = 8'h38, ASCII_9 = 8'h39;

  typedef enum logic [2:0] {
    ST_PWRUP, ST_INIT, ST_IDLE, ST_CHAR, ST_ADDR, ST_CLR
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE, PH_DELAY, PH_SETUP, PH_EN, PH_WAIT
  } phase_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Power-up command list, issued in index order.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY;
      default: return CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_char_writer_if.sv
// Request side (keypad decode) and LCD pin side of the character writer.
interface lcd_char_writer_if;
  logic [7:0] i_data;
  logic       i_wr;
  logic       i_clr;
  logic       o_busy;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  modport master (
    output i_data, i_wr, i_clr,
    input  o_busy, lcd_e, lcd_rs, lcd_rw, lcd_data
  );

  modport slave (
    input  i_data, i_wr, i_clr,
    output o_busy, lcd_e, lcd_rs, lcd_rw, lcd_data
  );
endinterface

// File: rtl/lcd_bus_cycle.sv
// One timed SETUP/EN/WAIT byte transfer on the LCD bus. Out of reset the same
// down-counter times the power-up delay, so it is the only timer in the design.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int unsigned T_MAX = max2(max2(max2(T_PWRUP, T_SETUP), max2(T_EN, T_CMD)), T_CLR);
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);

  phase_t           phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             long_q, long_n;
  logic             rs_n;
  logic [7:0]       data_n;
  logic             load_c;

  // A start in the final wait cycle chains straight into the next SETUP.
  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    long_n  = long_q;
    rs_n    = lcd_rs;
    data_n  = lcd_data;
    load_c  = 1'b0;
    case (phase)
      PH_IDLE: load_c = start;
      PH_DELAY, PH_WAIT: begin
        if (cnt == '0) begin
          if (start) load_c  = 1'b1;
          else       phase_n = PH_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      PH_SETUP: begin
        if (cnt == '0) begin
          phase_n = PH_EN;
          cnt_n   = CNT_W'(T_EN - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      PH_EN: begin
        if (cnt == '0) begin
          phase_n = PH_WAIT;
          cnt_n   = long_q ? CNT_W'(T_CLR - 1) : CNT_W'(T_CMD - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: phase_n = PH_IDLE;
    endcase
    if (load_c) begin
      phase_n = PH_SETUP;
      cnt_n   = CNT_W'(T_SETUP - 1);
      rs_n    = rs;
      data_n  = data;
      long_n  = long_wait;
    end
  end

  // done marks the last cycle of a wait so the sequencer can chain with no gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= PH_DELAY;
      cnt      <= CNT_W'(T_PWRUP - 1);
      long_q   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_e    <= 1'b0;
      done     <= (T_PWRUP == 1);
    end else begin
      phase    <= phase_n;
      cnt      <= cnt_n;
      long_q   <= long_n;
      lcd_rs   <= rs_n;
      lcd_data <= data_n;
      lcd_e    <= (phase_n == PH_EN);
      done     <= ((phase_n == PH_WAIT) || (phase_n == PH_DELAY)) && (cnt_n == '0);
    end
  end

endmodule

// File: rtl/lcd_char_writer.sv
// HD44780 character writer: power-up init, then one character or clear per
// request, with cursor tracking and automatic line change / wrap on a 2-line display.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000,
  parameter int unsigned COLS    = 16
) (
  input logic              clk,
  input logic              rst,
  lcd_char_writer_if.slave bus
);

  localparam int unsigned COL_W = $clog2(COLS + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  state_t           state;
  logic [1:0]       idx;
  logic [COL_W-1:0] col;
  logic             line;
  logic             busy;
  logic             done;
  logic             start_c;
  logic             rs_c;
  logic [7:0]       data_c;
  logic             long_c;
  logic             lcd_e, lcd_rs;
  logic [7:0]       lcd_data;

  // Byte to launch on the bus this cycle, if any.
  always_comb begin
    start_c = 1'b0;
    rs_c    = 1'b0;
    data_c  = 8'h00;
    case (state)
      ST_PWRUP: if (done) begin
        start_c = 1'b1;
        data_c  = init_cmd(2'd0);
      end
      ST_INIT: if (done && (idx != 2'd3)) begin
        start_c = 1'b1;
        data_c  = init_cmd(2'(idx + 2'd1));
      end
      ST_IDLE: begin
        if (bus.i_clr) begin
          start_c = 1'b1;
          data_c  = CLEAR;
        end else if (bus.i_wr) begin
          start_c = 1'b1;
          rs_c    = 1'b1;
          data_c  = bus.i_data;
        end
      end
      ST_CHAR: if (done && (col == LAST_COL)) begin
        start_c = 1'b1;
        data_c  = line ? LINE0 : LINE1;
      end
      default: ;
    endcase
  end

  assign long_c = !rs_c && ((data_c == CLEAR) || (data_c == HOME));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_PWRUP;
      idx   <= 2'd0;
      col   <= '0;
      line  <= 1'b0;
      busy  <= 1'b1;
    end else begin
      busy <= 1'b1;
      case (state)
        ST_PWRUP: if (done) begin
          state <= ST_INIT;
          idx   <= 2'd0;
        end
        ST_INIT: if (done) begin
          if (idx == 2'd3) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            col   <= '0;
            line  <= 1'b0;
          end else begin
            idx <= 2'(idx + 2'd1);
          end
        end
        ST_IDLE: begin
          if (bus.i_clr)     state <= ST_CLR;
          else if (bus.i_wr) state <= ST_CHAR;
          else               busy  <= 1'b0;
        end
        ST_CHAR: if (done) begin
          if (col == LAST_COL) begin
            state <= ST_ADDR;
          end else begin
            col   <= COL_W'(col + COL_W'(1));
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_ADDR: if (done) begin
          col   <= '0;
          line  <= ~line;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_CLR: if (done) begin
          col   <= '0;
          line  <= 1'b0;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_PWRUP;
      endcase
    end
  end

  lcd_bus_cycle #(
    .T_PWRUP (T_PWRUP),
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN),
    .T_CMD   (T_CMD),
    .T_CLR   (T_CLR)
  ) u_bus_cycle (
    .clk       (clk),
    .rst       (rst),
    .start     (start_c),
    .rs        (rs_c),
    .data      (data_c),
    .long_wait (long_c),
    .done      (done),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data)
  );

  assign bus.o_busy   = busy;
  assign bus.lcd_e    = lcd_e;
  assign bus.lcd_rs   = lcd_rs;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_data = lcd_data;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Scoreboard bench for lcd_char_writer: stimulus queues expected bus bytes,
// an E-edge monitor pops and compares them along with pulse width and stability.
module tb_lcd_char_writer;

  localparam int unsigned T_PWRUP = 20;
  localparam int unsigned T_SETUP = 2;
  localparam int unsigned T_EN    = 3;
  localparam int unsigned T_CMD   = 5;
  localparam int unsigned T_CLR   = 10;
  localparam int unsigned COLS    = 16;
  localparam int LIM = 2000;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } xfer_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  xfer_t exp_q[$];
  xfer_t cap;
  xfer_t exp_x;
  logic  in_pulse = 1'b0;
  logic  unstable;
  int    width;

  int   m_col;
  logic m_line;

  lcd_char_writer_if bus_if ();

  lcd_char_writer #(
    .T_PWRUP (T_PWRUP),
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN),
    .T_CMD   (T_CMD),
    .T_CLR   (T_CLR),
    .COLS    (COLS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic xfer_t mk(input logic rs, input logic [7:0] d);
    xfer_t x;
    x.rs   = rs;
    x.data = d;
    return x;
  endfunction

  // Monitor: one scoreboard pop per E rising edge.
  always @(negedge clk) begin
    if (rst) begin
      in_pulse = 1'b0;
    end else if (bus_if.lcd_e) begin
      if (!in_pulse) begin
        in_pulse = 1'b1;
        width    = 1;
        unstable = 1'b0;
        cap      = mk(bus_if.lcd_rs, bus_if.lcd_data);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse actual=rs%0d/%02h required=no pulse", cap.rs, cap.data);
        end else begin
          exp_x = exp_q.pop_front();
          check("pulse_byte", 32'(cap), 32'(exp_x));
        end
      end else begin
        width++;
        if (mk(bus_if.lcd_rs, bus_if.lcd_data) != cap) unstable = 1'b1;
      end
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      check("e_width", 32'(width), 32'(T_EN));
      check("bus_stable_during_e", 32'(unstable), 32'h0);
    end
  end

  // Counts negedges from the current one until o_busy is seen low.
  task automatic busy_len(output int n);
    n = 0;
    while (bus_if.o_busy === 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic push_init();
    exp_q.push_back(mk(1'b0, 8'h38));
    exp_q.push_back(mk(1'b0, 8'h0C));
    exp_q.push_back(mk(1'b0, 8'h06));
    exp_q.push_back(mk(1'b0, 8'h01));
    m_col  = 0;
    m_line = 1'b0;
  endtask

  // Releases reset at the current negedge and times the init sequence.
  task automatic release_and_init();
    int   n;
    int   first_e;
    logic early;
    push_init();
    rst     = 1'b0;
    n       = 0;
    first_e = 0;
    early   = 1'b0;
    while (bus_if.o_busy === 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
      if (n <= 20 && bus_if.lcd_e) early = 1'b1;
      if (first_e == 0 && bus_if.lcd_e) first_e = n;
    end
    check("pwrup_e_low", 32'(early), 32'h0);
    check("first_e_cycle", 32'(first_e), 32'd22);
    check("init_busy_cycles", 32'(n), 32'd65);
  endtask

  // Cursor model: queues the data byte plus any line-change address.
  task automatic model_write(input logic [7:0] d, output int exp_busy);
    exp_q.push_back(mk(1'b1, d));
    m_col++;
    exp_busy = 10;
    if (m_col == 16) begin
      exp_q.push_back(mk(1'b0, m_line ? 8'h80 : 8'hC0));
      m_line   = ~m_line;
      m_col    = 0;
      exp_busy = 20;
    end
  endtask

  task automatic do_write(input logic [7:0] d, input string name);
    int exp_busy;
    int n;
    model_write(d, exp_busy);
    bus_if.i_data = d;
    bus_if.i_wr   = 1'b1;
    @(negedge clk);
    bus_if.i_wr = 1'b0;
    busy_len(n);
    check(name, 32'(n), 32'(exp_busy));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   k;
    logic [7:0] d;

    rst           = 1'b0;
    bus_if.i_wr   = 1'b0;
    bus_if.i_clr  = 1'b0;
    bus_if.i_data = 8'h00;
    #1 rst = 1'b1;
    #2;
    check("rst_e", 32'(bus_if.lcd_e), 32'h0);
    check("rst_rs", 32'(bus_if.lcd_rs), 32'h0);
    check("rst_rw", 32'(bus_if.lcd_rw), 32'h0);
    check("rst_data", 32'(bus_if.lcd_data), 32'h0);
    check("rst_busy", 32'(bus_if.o_busy), 32'h1);
    repeat (3) @(negedge clk);
    check("rst_hold_busy", 32'(bus_if.o_busy), 32'h1);

    release_and_init();

    do_write(8'h35, "write_busy_35");

    // Clear and write together: clear wins, cursor back home.
    exp_q.push_back(mk(1'b0, 8'h01));
    m_col  = 0;
    m_line = 1'b0;
    bus_if.i_data = 8'h44;
    bus_if.i_wr   = 1'b1;
    bus_if.i_clr  = 1'b1;
    @(negedge clk);
    bus_if.i_wr  = 1'b0;
    bus_if.i_clr = 1'b0;
    busy_len(n);
    check("clr_busy", 32'(n), 32'd15);

    // 32 writes cover both line change and wrap back to line 0.
    for (int i = 0; i < 32; i++) begin
      d = 8'(8'h30 + 8'(i % 10));
      do_write(d, $sformatf("seq_write_busy_%0d", i + 1));
    end

    // Requests while busy are ignored; data is latched at acceptance.
    model_write(8'h41, n);
    bus_if.i_data = 8'h41;
    bus_if.i_wr   = 1'b1;
    @(negedge clk);
    bus_if.i_data = 8'h42;
    repeat (3) @(negedge clk);
    bus_if.i_wr = 1'b0;
    k = 3;
    while (bus_if.o_busy === 1'b1 && k < LIM) begin
      @(negedge clk);
      k++;
    end
    check("ignored_req_busy", 32'(k), 32'd10);
    repeat (20) @(negedge clk);
    check("ignored_req_idle", 32'(bus_if.o_busy), 32'h0);

    // Reset in the middle of a data pulse.
    exp_q.push_back(mk(1'b1, 8'h37));
    bus_if.i_data = 8'h37;
    bus_if.i_wr   = 1'b1;
    @(negedge clk);
    bus_if.i_wr = 1'b0;
    k = 0;
    while (!bus_if.lcd_e && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("e_high_before_rst", 32'(bus_if.lcd_e), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("midrst_e", 32'(bus_if.lcd_e), 32'h0);
    check("midrst_busy", 32'(bus_if.o_busy), 32'h1);
    check("midrst_data", 32'(bus_if.lcd_data), 32'h0);
    repeat (2) @(negedge clk);
    release_and_init();

    do_write(8'h39, "post_rst_write_busy");

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
